// File: rtl/spu_pkg.sv
// Shared SPU datapath definitions.
// Holds the default datapath widths, the EX/MEM payload struct and the
// occupancy state of the two-entry skid buffer used by elastic stages.
package spu_pkg;

    localparam int SPU_PC_W   = 32;
    localparam int SPU_DATA_W = 128;
    localparam int SPU_REG_W  = 7;

    // EX/MEM payload at the default widths.
    typedef struct packed {
        logic [SPU_PC_W-1:0]   jump_pc;
        logic                  zero;
        logic [SPU_DATA_W-1:0] alu_result;
        logic [SPU_DATA_W-1:0] store_data;
        logic [SPU_REG_W-1:0]  rt;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } ex_mem_t;

    // Occupancy of a two-entry skid buffer.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/spu_skid_buf.sv
// Generic two-entry valid/ready buffer with a synchronous flush.
// The main register is the head and drives out_data; the skid register
// catches the entry accepted while the head is back-pressured.
// Ports:
//   clk, reset (sync, active-high), flush (drops held entries)
//   in_valid / in_ready / in_data    : upstream handshake, in_ready registered
//   out_valid / out_ready / out_data : downstream handshake, head entry
module spu_skid_buf
    import spu_pkg::*;
#(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    skid_state_e state_q;
    logic        in_ready_q;
    T            main_q;
    T            skid_q;
    logic        push;
    logic        pop;

    assign push      = in_valid && in_ready_q;
    assign pop       = (state_q != SKID_EMPTY) && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = main_q;

    // in_ready_q is loaded with "next state is not FULL", so the upstream
    // ready never depends combinationally on out_ready.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // a blocking = here would let main_q <= skid_q see a freshly written skid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SKID_EMPTY;
            in_ready_q <= 1'b1;
            // NOTE: payload is reset as well because out_* must read zero
            // after reset; plain data storage would normally be left unreset.
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            // Only occupancy clears; payload registers keep their contents.
            state_q    <= SKID_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (push) begin
                        main_q  <= in_data;
                        state_q <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (push && !pop) begin
                        skid_q     <= in_data;
                        state_q    <= SKID_FULL;
                        in_ready_q <= 1'b0;
                    end else if (push && pop) begin
                        main_q <= in_data;
                    end else if (pop) begin
                        state_q <= SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (pop) begin
                        main_q     <= skid_q;
                        state_q    <= SKID_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= SKID_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/spu_ex_mem_stage.sv
// Elastic EX/MEM pipeline stage of the SPU datapath.
// Wraps a two-entry skid buffer around the EX/MEM payload and adds a
// forwarding tap from the head entry and a saturating stall counter.
// Ports:
//   clk, reset (sync, active-high), flush (drop held entries)
//   in_valid / in_ready, in_* : entry from EX
//   out_valid / out_ready, out_* : head entry towards MEM
//   fwd_valid / fwd_rt / fwd_data : forwarding tap, combinational from head
//   stall_count : saturating count of cycles with out_valid && !out_ready
module spu_ex_mem_stage
    import spu_pkg::*;
#(
    parameter int PC_W   = SPU_PC_W,
    parameter int DATA_W = SPU_DATA_W,
    parameter int REG_W  = SPU_REG_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_jump_pc,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_W-1:0]  in_rt,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_jump_pc,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_rt,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rt,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_count
);

    // Same layout as ex_mem_t but sized by this instance's parameters.
    typedef struct packed {
        logic [PC_W-1:0]   jump_pc;
        logic              zero;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rt;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } payload_t;

    payload_t in_payload;
    payload_t head;

    assign in_payload = '{
        jump_pc:    in_jump_pc,
        zero:       in_zero,
        alu_result: in_alu_result,
        store_data: in_store_data,
        rt:         in_rt,
        reg_write:  in_reg_write,
        mem_read:   in_mem_read,
        mem_write:  in_mem_write
    };

    spu_skid_buf #(
        .T (payload_t)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_jump_pc    = head.jump_pc;
    assign out_zero       = head.zero;
    assign out_alu_result = head.alu_result;
    assign out_store_data = head.store_data;
    assign out_rt         = head.rt;
    assign out_reg_write  = head.reg_write;
    assign out_mem_read   = head.mem_read;
    assign out_mem_write  = head.mem_write;

    // Forwarding tap: no added latency, straight off the head register.
    assign fwd_valid = out_valid && head.reg_write;
    assign fwd_rt    = head.rt;
    assign fwd_data  = head.alu_result;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // NOTE: the default assignment first keeps this block purely
    // combinational; without it stall_cnt_d would infer a latch.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_spu_ex_mem_stage.sv
// Self-checking bench for spu_ex_mem_stage: table-driven streaming vectors,
// directed multi-cycle sequences and a queue-based scoreboard watching
// every handshake.
module tb_spu_ex_mem_stage;
    import spu_pkg::*;

    localparam int CNT_W = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [SPU_PC_W-1:0]   in_jump_pc;
    logic                  in_zero;
    logic [SPU_DATA_W-1:0] in_alu_result;
    logic [SPU_DATA_W-1:0] in_store_data;
    logic [SPU_REG_W-1:0]  in_rt;
    logic                  in_reg_write;
    logic                  in_mem_read;
    logic                  in_mem_write;
    logic                  out_valid;
    logic                  out_ready;
    logic [SPU_PC_W-1:0]   out_jump_pc;
    logic                  out_zero;
    logic [SPU_DATA_W-1:0] out_alu_result;
    logic [SPU_DATA_W-1:0] out_store_data;
    logic [SPU_REG_W-1:0]  out_rt;
    logic                  out_reg_write;
    logic                  out_mem_read;
    logic                  out_mem_write;
    logic                  fwd_valid;
    logic [SPU_REG_W-1:0]  fwd_rt;
    logic [SPU_DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]      stall_count;

    spu_ex_mem_stage #(
        .PC_W   (SPU_PC_W),
        .DATA_W (SPU_DATA_W),
        .REG_W  (SPU_REG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_jump_pc     (in_jump_pc),
        .in_zero        (in_zero),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .in_rt          (in_rt),
        .in_reg_write   (in_reg_write),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_jump_pc    (out_jump_pc),
        .out_zero       (out_zero),
        .out_alu_result (out_alu_result),
        .out_store_data (out_store_data),
        .out_rt         (out_rt),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .fwd_valid      (fwd_valid),
        .fwd_rt         (fwd_rt),
        .fwd_data       (fwd_data),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    ex_mem_t sb_q[$];
    ex_mem_t in_pl;
    ex_mem_t out_pl;
    ex_mem_t zero_pl;

    assign in_pl = '{jump_pc: in_jump_pc, zero: in_zero, alu_result: in_alu_result,
                     store_data: in_store_data, rt: in_rt, reg_write: in_reg_write,
                     mem_read: in_mem_read, mem_write: in_mem_write};
    assign out_pl = '{jump_pc: out_jump_pc, zero: out_zero, alu_result: out_alu_result,
                      store_data: out_store_data, rt: out_rt, reg_write: out_reg_write,
                      mem_read: out_mem_read, mem_write: out_mem_write};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_pl(input string name, input ex_mem_t act, input ex_mem_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Scoreboard: sample handshakes on the falling edge, i.e. the values
    // that the next rising edge will act on.
    always @(negedge clk) begin
        if (reset || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_pop_has_entry", 128'(sb_q.size() != 0), 128'(1));
                if (sb_q.size() != 0) check_pl("sb_head", out_pl, sb_q.pop_front());
            end
            if (in_valid && in_ready) sb_q.push_back(in_pl);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input ex_mem_t p);
        in_valid      = v;
        in_jump_pc    = p.jump_pc;
        in_zero       = p.zero;
        in_alu_result = p.alu_result;
        in_store_data = p.store_data;
        in_rt         = p.rt;
        in_reg_write  = p.reg_write;
        in_mem_read   = p.mem_read;
        in_mem_write  = p.mem_write;
    endtask

    function automatic ex_mem_t mk(input logic [127:0] alu, input logic [6:0] rt, input logic rw);
        ex_mem_t p;
        p.jump_pc    = alu[31:0] ^ 32'hA5A5_0000;
        p.zero       = (alu == 128'd0);
        p.alu_result = alu;
        p.store_data = ~alu;
        p.rt         = rt;
        p.reg_write  = rw;
        p.mem_read   = alu[0];
        p.mem_write  = alu[1];
        return p;
    endfunction

    task automatic reset_dut();
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        ex_mem_t          pl;
        logic             exp_fwd_valid;
        logic [6:0]       exp_fwd_rt;
        logic [127:0]     exp_fwd_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        ex_mem_t pa, pb, pc;

        for (int i = 0; i < 8; i++) begin
            vecs[i].pl            = mk(128'(i), 7'(i + 1), (i % 3) != 0);
            vecs[i].exp_fwd_valid = (i % 3) != 0;
            vecs[i].exp_fwd_rt    = 7'(i + 1);
            vecs[i].exp_fwd_data  = 128'(i);
        end
        zero_pl   = '0;
        out_ready = 1'b0;
        set_in(1'b0, zero_pl);

        // Reset state.
        reset_dut();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check_pl("rst_payload", out_pl, zero_pl);
        check("rst_fwd_valid", 128'(fwd_valid), 128'(0));
        check("rst_fwd_rt", 128'(fwd_rt), 128'(0));
        check("rst_fwd_data", fwd_data, 128'(0));
        check("rst_stall", 128'(stall_count), 128'(0));

        // Single push, one-cycle latency, forwarding tap.
        out_ready = 1'b1;
        pa = mk(128'h1, 7'd5, 1'b1);
        set_in(1'b1, pa);
        tick();
        set_in(1'b0, zero_pl);
        check("t1_out_valid", 128'(out_valid), 128'(1));
        check("t1_alu", out_alu_result, 128'h1);
        check("t1_fwd_valid", 128'(fwd_valid), 128'(1));
        check("t1_fwd_rt", 128'(fwd_rt), 128'(5));
        tick();
        check("t1_drained", 128'(out_valid), 128'(0));

        // Back-pressure: two entries absorbed, third refused.
        out_ready = 1'b0;
        pa = mk(128'h10, 7'd10, 1'b1);
        pb = mk(128'h20, 7'd20, 1'b0);
        pc = mk(128'h30, 7'd30, 1'b1);
        set_in(1'b1, pa);
        tick();
        check("bp_ready_after_a", 128'(in_ready), 128'(1));
        set_in(1'b1, pb);
        tick();
        check("bp_ready_after_b", 128'(in_ready), 128'(0));
        check("bp_head_a", out_alu_result, 128'h10);
        set_in(1'b1, pc);
        tick();
        check("bp_c_refused", 128'(in_ready), 128'(0));
        check_pl("bp_head_still_a", out_pl, pa);
        set_in(1'b0, zero_pl);
        out_ready = 1'b1;
        tick();
        check("bp_b_valid", 128'(out_valid), 128'(1));
        check_pl("bp_head_b", out_pl, pb);
        tick();
        check("bp_empty", 128'(out_valid), 128'(0));
        check("bp_ready_back", 128'(in_ready), 128'(1));

        // Streaming from the vector table.
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, vecs[i].pl);
            tick();
            check($sformatf("st%0d_valid", i), 128'(out_valid), 128'(1));
            check_pl($sformatf("st%0d_out", i), out_pl, vecs[i].pl);
            check($sformatf("st%0d_fwd_valid", i), 128'(fwd_valid), 128'(vecs[i].exp_fwd_valid));
            check($sformatf("st%0d_fwd_rt", i), 128'(fwd_rt), 128'(vecs[i].exp_fwd_rt));
            check($sformatf("st%0d_fwd_data", i), fwd_data, vecs[i].exp_fwd_data);
            check($sformatf("st%0d_in_ready", i), 128'(in_ready), 128'(1));
        end
        set_in(1'b0, zero_pl);
        tick();
        check("st_empty", 128'(out_valid), 128'(0));
        check("st_stall", 128'(stall_count), 128'(0));

        // Flush while FULL with a new entry presented.
        out_ready = 1'b0;
        pa = mk(128'h40, 7'd4, 1'b1);
        pb = mk(128'h41, 7'd6, 1'b1);
        set_in(1'b1, pa);
        tick();
        set_in(1'b1, pb);
        tick();
        check("fl_full", 128'(in_ready), 128'(0));
        set_in(1'b1, mk(128'h99, 7'd9, 1'b1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(1'b0, zero_pl);
        check("fl_out_valid", 128'(out_valid), 128'(0));
        check("fl_in_ready", 128'(in_ready), 128'(1));
        check("fl_fwd_valid", 128'(fwd_valid), 128'(0));
        check("fl_payload_held", out_alu_result, 128'h40);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("fl_no_99_%0d", k), 128'(out_valid), 128'(0));
        end

        // Saturating stall counter (2 bits), survives flush.
        reset_dut();
        out_ready = 1'b0;
        set_in(1'b1, mk(128'h77, 7'd7, 1'b0));
        tick();
        set_in(1'b0, zero_pl);
        for (int j = 1; j <= 6; j++) begin
            tick();
            check($sformatf("sc_cycle%0d", j), 128'(stall_count), 128'((j < 3) ? j : 3));
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sc_after_flush", 128'(stall_count), 128'(3));
        tick();
        check("sc_hold_idle", 128'(stall_count), 128'(3));
        reset_dut();
        check("sc_after_reset", 128'(stall_count), 128'(0));

        // Reset mid-stream while FULL.
        out_ready = 1'b0;
        set_in(1'b1, mk(128'h55, 7'd9, 1'b1));
        tick();
        set_in(1'b1, mk(128'h66, 7'd11, 1'b1));
        tick();
        check("rm_full", 128'(in_ready), 128'(0));
        set_in(1'b1, mk(128'h88, 7'd12, 1'b1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_in(1'b0, zero_pl);
        check("rm_out_valid", 128'(out_valid), 128'(0));
        check("rm_in_ready", 128'(in_ready), 128'(1));
        check_pl("rm_payload", out_pl, zero_pl);
        check("rm_fwd_valid", 128'(fwd_valid), 128'(0));
        check("rm_fwd_rt", 128'(fwd_rt), 128'(0));
        check("rm_fwd_data", fwd_data, 128'(0));
        check("rm_stall", 128'(stall_count), 128'(0));

        out_ready = 1'b1;
        tick();
        tick();
        check("rm_stays_empty", 128'(out_valid), 128'(0));
        check("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spu_ex_mem_stage.md
# spu_ex_mem_stage

Parametrised, elastic EX/MEM pipeline stage for the SPU datapath, sitting between the execute stage and the local-store/memory stage. It carries the jump target, branch-zero flag, 128-bit ALU result, store data, destination register and control bits. Unlike a plain pipeline register, it uses a valid/ready handshake with a two-entry skid buffer, supports flush for branch mispredicts, exposes a forwarding tap and counts stall cycles.

## Interface
- PC_W, 32, jump PC width
- DATA_W, 128, ALU result / store data width
- REG_W, 7, register specifier width (128 registers)
- CNT_W, 16, stall counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  drop all held entries, synchronous
- in_valid  in  1  EX presents an entry
- in_ready  out  1  stage can accept; registered
- in_jump_pc  in  PC_W  branch/jump target
- in_zero  in  1  ALU zero flag
- in_alu_result  in  DATA_W  ALU result / address
- in_store_data  in  DATA_W  data for store
- in_rt  in  REG_W  destination register
- in_reg_write, in_mem_read, in_mem_write  in  1 each  control bits
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM consumes the head entry
- out_jump_pc, out_zero, out_alu_result, out_store_data, out_rt, out_reg_write, out_mem_read, out_mem_write  out  same widths as inputs  head entry fields
- fwd_valid  out  1  out_valid && out_reg_write
- fwd_rt  out  REG_W  equals out_rt
- fwd_data  out  DATA_W  equals out_alu_result
- stall_count  out  CNT_W  saturating count of back-pressured cycles

## Operation
- push = in_valid && in_ready. pop = out_valid && out_ready.
- Storage: main register (the head, which drives out_*) and skid register. State is EMPTY, ONE or FULL.
- EMPTY: push moves main<=in and goes to ONE.
- ONE:
  - push && !pop moves skid<=in and goes to FULL.
  - push && pop moves main<=in and stays in ONE.
  - !push && pop goes to EMPTY.
  - Otherwise hold.
- FULL: in_ready=0, so no push. pop moves main<=skid and goes to ONE. Otherwise hold.
- in_ready is asserted in the next cycle whenever the next state is not FULL.
- out_valid is 1 in ONE and FULL.
- Entries leave in strict FIFO order. No entry is duplicated or lost except by flush or reset.
- flush has priority over push and pop. The next state is EMPTY and in_ready=1 in the next cycle. An entry presented during the flush cycle is dropped. Payload registers keep their values; only the valid state clears.
- stall_count increments when out_valid && !out_ready and saturates at all-ones. It is cleared only by reset, not by flush.
- When out_valid=0, payload outputs hold their last values. Consumers must qualify them with out_valid.

## Timing
- Reset values:
  - State EMPTY, out_valid=0, in_ready=1.
  - All out_* payloads 0, fwd_valid=0, fwd_rt=0, fwd_data=0, stall_count=0.
- reset has priority over flush. A reset asserted mid-operation discards both entries.
- Latency: a push in cycle N with the stage empty gives out_valid=1 in cycle N+1.
- Throughput is one entry per cycle while out_ready=1.
- in_ready depends only on registers, never combinationally on out_ready. This breaks the ready path.
- fwd_* are combinational from the main register. There is no extra latency.
- With out_ready low, the stage absorbs exactly two entries and then deasserts in_ready.

## Structure
- Shared package spu_pkg holds:
  - a typedef for the EX/MEM payload struct ex_mem_t (jump_pc, zero, alu_result, store_data, rt, reg_write, mem_read, mem_write);
  - default width constants SPU_PC_W, SPU_DATA_W, SPU_REG_W;
  - the state enum for EMPTY/ONE/FULL.
- A natural sub-module is spu_skid_buf: a generic two-entry valid/ready buffer parametrised on payload type. spu_ex_mem_stage instantiates it and adds flush, forwarding and the stall counter.

## Test plan
- Reset, then push in_alu_result=0x1, rt=5, reg_write=1 with out_ready=1. Required next cycle: out_valid=1, out_alu_result=0x1, fwd_valid=1, fwd_rt=5.
- Back-pressure: out_ready=0, push A=0x10 then B=0x20. Required: in_ready=0 after the second push and the third input not accepted. After raising out_ready, A then B appear on consecutive cycles.
- Streaming: out_ready=1 and 8 consecutive pushes 0..7. Required: outputs 0..7 in order, one per cycle, in_ready constantly 1, stall_count=0.
- Flush while FULL and in_valid=1 with 0x99. Required next cycle: out_valid=0, in_ready=1, and 0x99 never appears.
- Stall counter with CNT_W=2: hold out_valid=1, out_ready=0 for 6 cycles. Required: stall_count=3 (saturated). It survives a flush and returns to 0 only after reset.
- Reset mid-stream while FULL. Required next cycle: out_valid=0, in_ready=1, all out_* and fwd_* equal 0.
